// File: rtl/apb_pkg.sv
// ============================================================================
// Module : apb_pkg
// Brief  : Shared widths, FSM encoding and slot decode codes for apb_master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int APB_AW   = 12;
  localparam int APB_DW   = 32;
  localparam int APB_NSLV = 3;

  // FSM encoding, kept as plain constants so older tools can consume it too
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    APB_IDLE   = ST_IDLE,
    APB_SETUP  = ST_SETUP,
    APB_ACCESS = ST_ACCESS
  } apb_state_t;

  // addr[9:8] slot codes; 2'b00 is left unmapped
  localparam logic [1:0] SLOT0_CODE = 2'b01;
  localparam logic [1:0] SLOT1_CODE = 2'b10;
  localparam logic [1:0] SLOT2_CODE = 2'b11;

  function automatic logic [APB_NSLV-1:0] slot_onehot(input logic [1:0] code);
    logic [APB_NSLV-1:0] sel;
    sel = '0;
    case (code)
      SLOT0_CODE: sel = 3'b001;
      SLOT1_CODE: sel = 3'b010;
      SLOT2_CODE: sel = 3'b100;
      default:    sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_addr_decoder.sv
// ============================================================================
// Module : apb_addr_decoder
// Brief  : Combinational 12-bit address to one-hot slave select decode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_addr_decoder
  import apb_pkg::*;
(
  input  logic [APB_AW-1:0]   i_addr,
  output logic [APB_NSLV-1:0] o_sel,
  output logic                o_mapped
);

  logic [APB_NSLV-1:0] w_sel;

  always_comb begin
    w_sel = slot_onehot(i_addr[9:8]);
  end

  assign o_sel    = w_sel;
  assign o_mapped = |w_sel;

endmodule

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// Module : apb_master
// Brief  : APB3 bridge master - local request to registered IDLE/SETUP/ACCESS.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master
  import apb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic [APB_AW-1:0]   addr_in,
  input  logic                wr_in,
  input  logic [APB_DW-1:0]   data_in,
  input  logic                ready,
  output logic [APB_NSLV-1:0] sel_port,
  output logic                en,
  output logic                wr_out,
  output logic [APB_AW-1:0]   addr_out,
  output logic [APB_DW-1:0]   data_out
);

  logic [APB_NSLV-1:0] w_dec_sel;
  logic                w_mapped;
  logic                w_req;
  logic                w_load;

  logic [1:0]          r_state;
  logic [APB_NSLV-1:0] r_sel_port;
  logic                r_en;
  logic                r_wr;
  logic [APB_AW-1:0]   r_addr;
  logic [APB_DW-1:0]   r_data;

  apb_addr_decoder u_dec (
    .i_addr   (addr_in),
    .o_sel    (w_dec_sel),
    .o_mapped (w_mapped)
  );

  // A new transfer may be accepted from IDLE or at the completing ACCESS edge
  assign w_req  = sel & w_mapped;
  assign w_load = w_req & ((r_state == ST_IDLE) | ((r_state == ST_ACCESS) & ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel_port <= '0;
      r_en       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state    <= ST_SETUP;
            r_sel_port <= w_dec_sel;
            r_en       <= 1'b0;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_en    <= 1'b1;
        end
        ST_ACCESS: begin
          if (ready) begin
            r_en <= 1'b0;
            if (w_req) begin
              r_state    <= ST_SETUP;
              r_sel_port <= w_dec_sel;
            end else begin
              r_state    <= ST_IDLE;
              r_sel_port <= '0;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_sel_port <= '0;
          r_en       <= 1'b0;
        end
      endcase
    end
  end

  // Payload; write data is only refreshed by writes so reads leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_load) begin
      r_wr   <= wr_in;
      r_addr <= addr_in;
      if (wr_in) begin
        r_data <= data_in;
      end
    end
  end

  assign sel_port = r_sel_port;
  assign en       = r_en;
  assign wr_out   = r_wr;
  assign addr_out = r_addr;
  assign data_out = r_data;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module : tb_apb_master
// Brief  : Directed plus randomized bench for apb_master with transfer model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [11:0] addr_in = '0;
  logic        wr_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        ready = 1'b0;
  logic [2:0]  sel_port;
  logic        en;
  logic        wr_out;
  logic [11:0] addr_out;
  logic [31:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  // Transfer-level model: is a transfer open, has it reached its enable phase
  bit          m_busy;
  bit          m_acc;
  logic [2:0]  m_sel;
  logic        m_wr;
  logic [11:0] m_addr;
  logic [31:0] m_data;

  apb_master dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .addr_in  (addr_in),
    .wr_in    (wr_in),
    .data_in  (data_in),
    .ready    (ready),
    .sel_port (sel_port),
    .en       (en),
    .wr_out   (wr_out),
    .addr_out (addr_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] slot_of(input logic [11:0] a);
    case (a[9:8])
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_sel = '0; m_wr = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_accept();
    m_busy = 1; m_acc = 0;
    m_sel  = slot_of(addr_in);
    m_addr = addr_in;
    m_wr   = wr_in;
    if (wr_in) m_data = data_in;
  endtask

  task automatic model_step();
    bit req;
    req = sel && (slot_of(addr_in) != 3'b000);
    if (!m_busy) begin
      if (req) model_accept();
    end else if (!m_acc) begin
      m_acc = 1;
    end else if (ready) begin
      if (req) model_accept();
      else m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    check("sel_port", 32'(sel_port), m_busy ? 32'(m_sel) : 32'd0);
    check("en", 32'(en), 32'(m_busy && m_acc));
    if (m_busy) begin
      check("addr_out", 32'(addr_out), 32'(m_addr));
      check("wr_out", 32'(wr_out), 32'(m_wr));
    end
    if (m_busy && m_wr) check("data_out", data_out, m_data);
  endtask

  // Advance one cycle: model follows the edge, outputs checked at the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic s, input logic [11:0] a, input logic w,
                       input logic [31:0] d, input logic r);
    sel = s; addr_in = a; wr_in = w; data_in = d; ready = r;
  endtask

  // Called at a falling edge; reset lands mid-cycle and must act without a clock
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_sel", 32'(sel_port), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_wr", 32'(wr_out), 32'd0);
    check("rst_data", data_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();
    tick();
    check("idle_sel", 32'(sel_port), 32'd0);

    // Zero-wait write to slot 2, then back-to-back because sel stays high
    drive(1, 12'h300, 1, 32'd13, 1);
    tick();
    check("w0_sel", 32'(sel_port), 32'b100);
    check("w0_en", 32'(en), 32'd0);
    check("w0_addr", 32'(addr_out), 32'h300);
    check("w0_data", data_out, 32'd13);
    tick();
    check("w0_en_acc", 32'(en), 32'd1);
    tick();
    check("b2b_en", 32'(en), 32'd0);
    check("b2b_sel", 32'(sel_port), 32'b100);
    sel = 0;
    tick();
    tick();
    check("w0_idle", 32'(sel_port), 32'd0);

    // Wait states: ready low for three ACCESS edges
    drive(1, 12'h100, 1, 32'h55, 0);
    tick();
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ws_en", 32'(en), 32'd1);
      check("ws_sel", 32'(sel_port), 32'b001);
    end
    ready = 1;
    tick();
    check("ws_done", 32'(en), 32'd0);
    check("ws_idle", 32'(sel_port), 32'd0);

    // Read to slot 1; write data keeps its last written value
    drive(1, 12'h2A4, 0, 32'hDEAD, 1);
    tick();
    check("rd_sel", 32'(sel_port), 32'b010);
    check("rd_wr", 32'(wr_out), 32'd0);
    check("rd_addr", 32'(addr_out), 32'h2A4);
    sel = 0;
    tick();
    check("rd_en", 32'(en), 32'd1);
    tick();
    check("rd_idle", 32'(sel_port), 32'd0);

    // Unmapped request is ignored
    drive(1, 12'h0FF, 1, 32'h1, 1);
    tick();
    tick();
    check("unm_sel", 32'(sel_port), 32'd0);
    check("unm_en", 32'(en), 32'd0);

    // Inputs changing mid-transfer, then reset during ACCESS
    drive(1, 12'h204, 1, 32'hAAAA_0001, 0);
    tick();
    drive(1, 12'h3FF, 0, 32'hBBBB_0002, 0);
    tick();
    tick();
    check("hold_data", data_out, 32'hAAAA_0001);
    check("hold_addr", 32'(addr_out), 32'h204);
    check("hold_wr", 32'(wr_out), 32'd1);
    async_reset();

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      sel     = ($urandom_range(0, 9) < 7);
      addr_in = 12'($urandom);
      wr_in   = 1'($urandom);
      data_in = $urandom;
      ready   = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 199) == 0) async_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB3-style bridge master for the SoC APB interconnect. Converts a simple local request (address, write flag, write data, request strobe) into a registered APB transfer. It decodes the 12-bit address into a one-hot select for three peripheral slots and sequences the IDLE/SETUP/ACCESS phases against the slave `ready`. Sits between the bus-side request source and the APB slave mux.

## Interface
- Reset: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).
- Parameters: none; widths fixed (address 12, data 32, 3 slave slots).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `sel` in 1: transfer request; sampled in IDLE and at ACCESS completion.
- `addr_in` in 12: request address.
- `wr_in` in 1: 1 = write, 0 = read.
- `data_in` in 32: write data.
- `ready` in 1: slave PREADY.
- `sel_port` out 3: one-hot PSEL per slave slot.
- `en` out 1: PENABLE.
- `wr_out` out 1: PWRITE.
- `addr_out` out 12: PADDR.
- `data_out` out 32: PWDATA.

## Operation
- States: IDLE, SETUP, ACCESS (2-bit encoding).
- Address decode on `addr_in[9:8]`:
  - 01 → `sel_port` = 3'b001.
  - 10 → 3'b010.
  - 11 → 3'b100.
  - 00 → unmapped.
- `addr_in[11:10]` and `[7:0]` pass through unchanged on `addr_out`.
- IDLE:
  - If `sel`=1 and address mapped: latch `addr_in`, `wr_in`, `data_in` and the decoded select; go to SETUP.
  - If `sel`=1 and address unmapped: ignore the request and stay in IDLE.
- SETUP: `sel_port` = latched select, `en`=0. Always go to ACCESS on the next edge.
- ACCESS:
  - `en`=1; select, address, write flag and data held stable.
  - `ready`=0: stay in ACCESS (wait states, unbounded).
  - `ready`=1 and `sel`=1 with a mapped address: latch the new request and go to SETUP (back-to-back transfer).
  - `ready`=1 otherwise: go to IDLE.
- Reads: `wr_out`=0. `data_out` holds its last written value and is don't-care to slaves. Read data returns from the slave directly through the interconnect and does not pass through this block.
- `data_out` and `wr_out` are valid only while `sel_port`≠0.

## Timing
- All outputs are registered. There is no combinational input→output path.
- Reset (asserts asynchronously): state IDLE; `sel_port`=0, `en`=0, `wr_out`=0, `addr_out`=0, `data_out`=0.
- Request `sel` sampled high at IDLE edge N:
  - SETUP outputs are visible after edge N.
  - ACCESS (`en`=1) is visible after edge N+1.
- Completion happens at the first edge in ACCESS with `ready`=1. Minimum transfer is 2 cycles.
- After completion:
  - Return to IDLE: `sel_port`=0 and `en`=0 after that edge.
  - Back-to-back: `en`=0 for exactly one cycle (the SETUP phase) between transfers.
- `ready` is ignored in IDLE and SETUP.
- Changes to `addr_in`, `wr_in` or `data_in` during SETUP or ACCESS do not affect the transfer in flight.
- Reset mid-transfer aborts it immediately. No completion is signalled.

## Structure
- Package `apb_pkg` holds:
  - `apb_state_t` enum (IDLE, SETUP, ACCESS).
  - Widths: `APB_AW`=12, `APB_DW`=32, `APB_NSLV`=3.
  - Decode constants for the `addr_in[9:8]` slot codes.
- Sub-module `apb_addr_decoder`: combinational, 12-bit address → 3-bit one-hot select plus `mapped` flag.
- Top level: FSM plus output registers.

## Test plan
- Reset: assert `rst` mid-clock → all outputs 0 immediately, no clock edge needed. Release → stays IDLE with `sel`=0.
- Single write, zero wait:
  - Stimulus: `addr_in`=0x300, `wr_in`=1, `data_in`=13, `sel`=1, `ready`=1.
  - Cycle 1: `sel_port`=100, `addr_out`=0x300, `wr_out`=1, `data_out`=13, `en`=0.
  - Cycle 2: same, with `en`=1.
  - Then: back-to-back SETUP, since `sel` is still 1.
- Wait states: write to 0x100 with `ready`=0 for 3 cycles → `sel_port`=001, `en`=1 held 4 cycles. Completes on the edge where `ready`=1. Returns to IDLE when `sel`=0.
- Read: `addr_in`=0x2A4, `wr_in`=0 → `sel_port`=010, `wr_out`=0, `addr_out`=0x2A4. 2-cycle transfer.
- Unmapped: `addr_in`=0x0FF with `sel`=1 → stays IDLE, `sel_port`=0, `en`=0.
- Input change and reset mid-transfer:
  - Change `data_in` during ACCESS → `data_out` keeps its latched value.
  - Assert `rst` during ACCESS → outputs 0 at once.
